// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces two coin sensors and emits one-cycle coin codes.
// Optional credit tally is built when COIN_TALLY_EN is defined; otherwise tally is tied to zero.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 200,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_lo,
  input  logic       sensor_hi,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic [7:0] tally
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DEBOUNCE     = 3'd1,
    EMIT         = 3'd2,
    WAIT_RELEASE = 3'd3,
    JAM          = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] JAM_MAX  = CNT_W'(JAM_CYCLES);

  logic [1:0]       sync1_r, sync2_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s, run_s;
  logic [1:0]       sel_r, sel_s;
  logic             prev_any_r, any_s;
  logic [1:0]       coin_r, coin_s;
  logic             reject_r, reject_s;
  logic             jam_r;

  // Bit 1 is the high-denomination line so a latched pattern doubles as the coin code.
  assign any_s     = |sync2_r;
  assign cnt_inc_s = cnt_r + CNT_ONE;
  // Shared counter restarts at 1 whenever the release phase flips between high-run and low-run.
  assign run_s     = (any_s == prev_any_r) ? cnt_inc_s : CNT_ONE;

  // Two-flop synchronisers for both raw sensor lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {sensor_hi, sensor_lo};
      sync2_r <= sync1_r;
    end
  end

  // FSM state, shared counter, latched sensor pattern and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      sel_r      <= 2'b00;
      prev_any_r <= 1'b0;
      coin_r     <= 2'b00;
      reject_r   <= 1'b0;
      jam_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      sel_r      <= sel_s;
      prev_any_r <= any_s;
      coin_r     <= coin_s;
      reject_r   <= reject_s;
      jam_r      <= (state_s == JAM);
    end
  end

  // Next-state logic; coin/reject are decided on entry to EMIT so they are live during EMIT.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    sel_s    = sel_r;
    coin_s   = 2'b00;
    reject_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          sel_s   = sync2_r;
          cnt_s   = CNT_ZERO;
          state_s = DEBOUNCE;
        end else begin
          state_s = IDLE;
        end
      end
      DEBOUNCE: begin
        if (sync2_r != sel_r) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else if (cnt_r == DB_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = EMIT;
          if ((sel_r == 2'b11) || !accept_en) begin
            reject_s = 1'b1;
          end else begin
            coin_s = sel_r;
          end
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      EMIT: begin
        cnt_s   = CNT_ZERO;
        state_s = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (any_s && (run_s == JAM_MAX)) begin
          cnt_s   = CNT_ZERO;
          state_s = JAM;
        end else if (!any_s && (run_s == DB_MAX)) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else begin
          cnt_s = run_s;
        end
      end
      JAM: begin
        if (any_s) begin
          cnt_s = CNT_ZERO;
        end else if (cnt_inc_s == DB_MAX) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        sel_s   = 2'b00;
        state_s = IDLE;
      end
    endcase
  end

  assign coin   = coin_r;
  assign reject = reject_r;
  assign jam    = jam_r;

`ifdef COIN_TALLY_EN
  logic [7:0] tally_r;
  logic [8:0] tally_sum_s;

  // Low coin code 01 adds 1 and high code 10 adds 2, so the code itself is the increment.
  assign tally_sum_s = {1'b0, tally_r} + {7'd0, coin_s};

  // Saturating credit tally, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tally_r <= 8'd0;
    end else if (tally_sum_s[8]) begin
      tally_r <= 8'hFF;
    end else begin
      tally_r <= tally_sum_s[7:0];
    end
  end

  assign tally = tally_r;
`else
  assign tally = 8'd0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor; tally expectations follow COIN_TALLY_EN.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_lo;
  logic       sensor_hi;
  logic       accept_en;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
  logic [7:0] tally;

  int checks = 0;
  int errors = 0;
  int lo_pulses = 0;
  int hi_pulses = 0;
  int rej_pulses = 0;
  int bad_events = 0;
  int credit = 0;
  logic [1:0] prev_coin = 2'b00;
  logic       prev_rej = 1'b0;

`ifdef COIN_TALLY_EN
  localparam bit TALLY_ON = 1'b1;
`else
  localparam bit TALLY_ON = 1'b0;
`endif

  coin_acceptor dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_lo (sensor_lo),
    .sensor_hi (sensor_hi),
    .accept_en (accept_en),
    .coin      (coin),
    .reject    (reject),
    .jam       (jam),
    .tally     (tally)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_tally(input int c);
    if (!TALLY_ON) return 8'd0;
    if (c > 255) return 8'd255;
    return 8'(c);
  endfunction

  // Pulse counters and protocol watch: no 11 code, no held code/reject, no code with reject or jam.
  always @(negedge clk) begin
    if (rst) begin
      prev_coin <= 2'b00;
      prev_rej  <= 1'b0;
    end else begin
      if (coin == 2'b01) lo_pulses <= lo_pulses + 1;
      if (coin == 2'b10) hi_pulses <= hi_pulses + 1;
      if (reject) rej_pulses <= rej_pulses + 1;
      if ((coin == 2'b11) || (coin != 2'b00 && prev_coin != 2'b00) || (reject && prev_rej) ||
          (coin != 2'b00 && (reject || jam))) begin
        bad_events <= bad_events + 1;
      end
      prev_coin <= coin;
      prev_rej  <= reject;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sensor_lo = 1'b0; sensor_hi = 1'b0; accept_en = 1'b1;
    repeat (2) step();
    checks++; if (coin !== 2'b00) begin errors++; $display("FAIL reset_coin: got %b expected 00", coin); end
    checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b expected 0", reject); end
    checks++; if (jam !== 1'b0) begin errors++; $display("FAIL reset_jam: got %b expected 0", jam); end
    checks++; if (tally !== 8'd0) begin errors++; $display("FAIL reset_tally: got %0d expected 0", tally); end
    rst = 1'b0;
    credit = 0;
  endtask

  task automatic test_low_coin();
    int lo0, rej0;
    lo0 = lo_pulses; rej0 = rej_pulses;
    sensor_lo = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 6) begin checks++; if (coin !== 2'b00) begin errors++; $display("FAIL low_early: got %b expected 00", coin); end end
      if (i == 7) begin
        checks++; if (coin !== 2'b01) begin errors++; $display("FAIL low_latency: got %b expected 01", coin); end
        checks++; if (reject !== 1'b0) begin errors++; $display("FAIL low_reject: got %b expected 0", reject); end
      end
      if (i == 8) begin checks++; if (coin !== 2'b00) begin errors++; $display("FAIL low_width: got %b expected 00", coin); end end
    end
    sensor_lo = 1'b0;
    credit += 1;
    repeat (8) step();
    checks++; if (lo_pulses - lo0 != 1) begin errors++; $display("FAIL low_count: got %0d expected 1", lo_pulses - lo0); end
    checks++; if (rej_pulses != rej0) begin errors++; $display("FAIL low_rej_count: got %0d expected 0", rej_pulses - rej0); end
    checks++; if (tally !== exp_tally(credit)) begin errors++; $display("FAIL low_tally: got %0d expected %0d", tally, exp_tally(credit)); end
  endtask

  task automatic test_glitch();
    int hi0, rej0;
    hi0 = hi_pulses; rej0 = rej_pulses;
    sensor_hi = 1'b1;
    repeat (3) step();
    sensor_hi = 1'b0;
    repeat (10) step();
    checks++; if (hi_pulses != hi0) begin errors++; $display("FAIL glitch_coin: got %0d pulses expected 0", hi_pulses - hi0); end
    checks++; if (rej_pulses != rej0) begin errors++; $display("FAIL glitch_reject: got %0d pulses expected 0", rej_pulses - rej0); end
  endtask

  task automatic test_disabled();
    int lo0, hi0, rej0;
    lo0 = lo_pulses; hi0 = hi_pulses; rej0 = rej_pulses;
    for (int pass = 0; pass < 2; pass++) begin
      accept_en = (pass == 1);
      sensor_hi = 1'b1;
      sensor_lo = (pass == 1);
      for (int i = 1; i <= 10; i++) begin
        step();
        if (i == 6) begin checks++; if (reject !== 1'b0) begin errors++; $display("FAIL rej_early%0d: got %b expected 0", pass, reject); end end
        if (i == 7) begin
          checks++; if (reject !== 1'b1) begin errors++; $display("FAIL rej_pulse%0d: got %b expected 1", pass, reject); end
          checks++; if (coin !== 2'b00) begin errors++; $display("FAIL rej_coin%0d: got %b expected 00", pass, coin); end
        end
        if (i == 8) begin checks++; if (reject !== 1'b0) begin errors++; $display("FAIL rej_width%0d: got %b expected 0", pass, reject); end end
      end
      sensor_hi = 1'b0; sensor_lo = 1'b0;
      repeat (8) step();
    end
    accept_en = 1'b1;
    checks++; if (rej_pulses - rej0 != 2) begin errors++; $display("FAIL rej_count: got %0d expected 2", rej_pulses - rej0); end
    checks++; if ((lo_pulses != lo0) || (hi_pulses != hi0)) begin errors++; $display("FAIL rej_codes: got lo=%0d hi=%0d expected 0 0", lo_pulses - lo0, hi_pulses - hi0); end
    checks++; if (tally !== exp_tally(credit)) begin errors++; $display("FAIL rej_tally: got %0d expected %0d", tally, exp_tally(credit)); end
  endtask

  task automatic test_jam();
    int lo0;
    lo0 = lo_pulses;
    sensor_lo = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      step();
      if (i == 7) begin checks++; if (coin !== 2'b01) begin errors++; $display("FAIL jam_coin: got %b expected 01", coin); end end
      if (i == 207) begin checks++; if (jam !== 1'b0) begin errors++; $display("FAIL jam_early: got %b expected 0", jam); end end
      if (i == 208) begin checks++; if (jam !== 1'b1) begin errors++; $display("FAIL jam_set: got %b expected 1", jam); end end
    end
    credit += 1;
    checks++; if (lo_pulses - lo0 != 1) begin errors++; $display("FAIL jam_single: got %0d expected 1", lo_pulses - lo0); end
    sensor_lo = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) begin checks++; if (jam !== 1'b1) begin errors++; $display("FAIL jam_hold: got %b expected 1", jam); end end
      if (i == 6) begin checks++; if (jam !== 1'b0) begin errors++; $display("FAIL jam_clear: got %b expected 0", jam); end end
    end
    sensor_hi = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) begin checks++; if (coin !== 2'b10) begin errors++; $display("FAIL jam_recover: got %b expected 10", coin); end end
    end
    sensor_hi = 1'b0;
    credit += 2;
    repeat (8) step();
    checks++; if (tally !== exp_tally(credit)) begin errors++; $display("FAIL jam_tally: got %0d expected %0d", tally, exp_tally(credit)); end
  endtask

  task automatic test_back_to_back();
    int hi0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    credit = 0;
    sensor_lo = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 7) begin checks++; if (coin !== 2'b01) begin errors++; $display("FAIL b2b_lo: got %b expected 01", coin); end end
    end
    sensor_lo = 1'b0;
    repeat (6) step();
    hi0 = hi_pulses;
    sensor_hi = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 7) begin checks++; if (coin !== 2'b10) begin errors++; $display("FAIL b2b_hi: got %b expected 10", coin); end end
    end
    sensor_hi = 1'b0;
    repeat (6) step();
    credit = 3;
    checks++; if (tally !== exp_tally(credit)) begin errors++; $display("FAIL b2b_tally: got %0d expected %0d", tally, exp_tally(credit)); end
    for (int i = 1; i <= 130; i++) begin
      sensor_hi = 1'b1;
      repeat (8) step();
      sensor_hi = 1'b0;
      repeat (6) step();
      credit += 2;
      if (i >= 125 && i <= 127) begin
        checks++;
        if (tally !== exp_tally(credit)) begin errors++; $display("FAIL sat_tally_%0d: got %0d expected %0d", i, tally, exp_tally(credit)); end
      end
    end
    checks++; if (tally !== exp_tally(credit)) begin errors++; $display("FAIL sat_final: got %0d expected %0d", tally, exp_tally(credit)); end
    checks++; if (hi_pulses - hi0 != 131) begin errors++; $display("FAIL sat_count: got %0d expected 131", hi_pulses - hi0); end
  endtask

  task automatic test_reset_mid();
    int lo0;
    sensor_lo = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    #1;
    checks++; if (coin !== 2'b00 || reject !== 1'b0 || jam !== 1'b0) begin errors++; $display("FAIL mid_outputs: got coin=%b reject=%b jam=%b expected 00 0 0", coin, reject, jam); end
    checks++; if (tally !== 8'd0) begin errors++; $display("FAIL mid_tally: got %0d expected 0", tally); end
    repeat (2) step();
    rst = 1'b0;
    credit = 0;
    lo0 = lo_pulses;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 6) begin checks++; if (coin !== 2'b00) begin errors++; $display("FAIL mid_early: got %b expected 00", coin); end end
      if (i == 7) begin checks++; if (coin !== 2'b01) begin errors++; $display("FAIL mid_recoin: got %b expected 01", coin); end end
    end
    sensor_lo = 1'b0;
    credit += 1;
    repeat (8) step();
    checks++; if (lo_pulses - lo0 != 1) begin errors++; $display("FAIL mid_count: got %0d expected 1", lo_pulses - lo0); end
    checks++; if (tally !== exp_tally(credit)) begin errors++; $display("FAIL mid_tally_after: got %0d expected %0d", tally, exp_tally(credit)); end
  endtask

  initial begin
    rst = 1'b1; sensor_lo = 1'b0; sensor_hi = 1'b0; accept_en = 1'b1;
    @(negedge clk);
    test_reset();
    test_low_coin();
    test_glitch();
    test_disabled();
    test_jam();
    test_back_to_back();
    test_reset_mid();
    repeat (2) step();
    checks++; if (bad_events != 0) begin errors++; $display("FAIL protocol: got %0d bad cycles expected 0", bad_events); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
